cfg_chain_loader: RTL and testbench

Sequences loading of a configuration shift chain built from enable/preset flops in the fabric tech library. Accepts configuration words over a valid/ready stream and presets the whole chain to ones. Serialises the words LSB-first onto the chain using the chain's shared enable as the shift strobe, then flags completion. Sits between the bitstream source (SPI/JTAG front end) and the fabric config chain.

---
 rtl/cfg_loader_pkg.sv | 23 ++
 rtl/cfg_chain_loader_if.sv | 17 +
 rtl/cfg_word_serializer.sv | 54 +++++
 rtl/cfg_chain_loader.sv | 155 +++++++++++++++
 tb/tb_cfg_chain_loader.sv | 224 ++++++++++++++++++++++
 5 files changed

// File: rtl/cfg_loader_pkg.sv
// cfg_loader_pkg
//   Shared types for the configuration chain loader: FSM state encoding and
//   the elaboration-parameter sanity helper used by the loader's assertion.
//   No ports.
package cfg_loader_pkg;

  localparam int STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE   = 3'd0,
    ST_PRESET = 3'd1,
    ST_LOAD   = 3'd2,
    ST_CHECK  = 3'd3,
    ST_DONE   = 3'd4
  } state_t;

  // The chain must hold a whole number of words, otherwise the last word
  // would be split across the end of the chain.
  function automatic bit chain_len_ok(input int chain_len, input int word_w);
    return (word_w > 0) && (chain_len > 0) && ((chain_len % word_w) == 0);
  endfunction

endpackage

// File: rtl/cfg_chain_loader_if.sv
// cfg_chain_loader_if
//   Valid/ready word stream from the bitstream source into the loader.
//   Parameter: WORD_W  word width
//   Signals:   in_data  [WORD_W]  configuration word (source -> loader)
//              in_valid           in_data valid     (source -> loader)
//              in_ready           loader accepts    (loader -> source)
//   Modports:  master = source side, slave = loader side.
interface cfg_chain_loader_if #(
  parameter int WORD_W = 8
);
  logic [WORD_W-1:0] in_data;
  logic              in_valid;
  logic              in_ready;

  modport master (output in_data, output in_valid, input in_ready);
  modport slave  (input in_data, input in_valid, output in_ready);
endinterface

// File: rtl/cfg_word_serializer.sv
// cfg_word_serializer
//   Holds one configuration word and shifts it LSB-first onto the chain.
//   Ports: clk, rst        clock, synchronous active-high reset
//          load, word      capture word (allowed when empty or on last bit)
//          full            a word is being shifted this cycle
//          last_bit        current cycle shifts the word's final bit
//          chain_d         serial data to chain head (flop output)
//          chain_e         chain shift enable (flop output)
module cfg_word_serializer #(
  parameter int WORD_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [WORD_W-1:0] word,
  output logic              full,
  output logic              last_bit,
  output logic              chain_d,
  output logic              chain_e
);

  localparam int BW = (WORD_W > 1) ? $clog2(WORD_W) : 1;

  logic [WORD_W-1:0] shreg;
  logic [BW-1:0]     bitcnt;

  assign last_bit = full && (bitcnt == BW'(WORD_W - 1));
  // The register is zeroed whenever it empties, so bit 0 is already 0 while
  // the chain holds and chain_d can come straight off the flop.
  assign chain_d  = shreg[0];
  assign chain_e  = full;

  always_ff @(posedge clk) begin
    if (rst) begin
      full   <= 1'b0;
      shreg  <= '0;
      bitcnt <= '0;
    end else if (load) begin
      full   <= 1'b1;
      shreg  <= word;
      bitcnt <= '0;
    end else if (full) begin
      if (last_bit) begin
        full   <= 1'b0;
        shreg  <= '0;
        bitcnt <= '0;
      end else begin
        shreg  <= shreg >> 1;
        bitcnt <= bitcnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/cfg_chain_loader.sv
// cfg_chain_loader
//   Presets the fabric configuration chain to ones, then serialises incoming
//   words LSB-first onto it using the shared chain enable as shift strobe,
//   and pulses done when the whole chain has been loaded.
//   Optional build macro CFG_LOADER_CRC_EN: after the payload one extra
//   trailer word is accepted and compared with the XOR of all payload words;
//   a mismatch raises err at the done cycle. Without it err is tied low.
//   Ports: clk, rst   clock, synchronous active-high reset
//          start      begin a load (only honoured in IDLE)
//          stream     word stream, slave side (in_data/in_valid/in_ready)
//          chain_d    serial data into chain head
//          chain_e    chain shift enable
//          chain_s    chain preset, active low
//          busy       high outside IDLE
//          done       one-cycle end-of-load pulse
//          err        checksum mismatch, held until next start
//
//   state   | meaning
//   IDLE    | waiting for start
//   PRESET  | chain_s low for PRESET_CYCLES cycles
//   LOAD    | accepting words and shifting them onto the chain
//   CHECK   | waiting for the checksum trailer word (CRC build only)
//   DONE    | one-cycle done pulse
module cfg_chain_loader
  import cfg_loader_pkg::*;
#(
  parameter int CHAIN_LEN     = 64,
  parameter int WORD_W        = 8,
  parameter int PRESET_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  cfg_chain_loader_if.slave stream,
  output logic              chain_d,
  output logic              chain_e,
  output logic              chain_s,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam int TW = $clog2(CHAIN_LEN + 1);
  localparam int PW = (PRESET_CYCLES > 1) ? $clog2(PRESET_CYCLES) : 1;

  state_t        state, state_n;
  logic [PW-1:0] pre_cnt;
  logic [TW-1:0] bits_acc;
  logic          in_ready;
  logic          start_fire;
  logic          load_fire;
  logic          words_left;
  logic          ser_full;
  logic          ser_last;

  assign start_fire      = (state == ST_IDLE) && start;
  assign words_left      = bits_acc < TW'(CHAIN_LEN);
  assign load_fire       = (state == ST_LOAD) && stream.in_valid && in_ready;
  assign stream.in_ready = in_ready;

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n  = state;
    in_ready = 1'b0;
    case (state)
      ST_IDLE:   if (start) state_n = ST_PRESET;
      ST_PRESET: if (pre_cnt == '0) state_n = ST_LOAD;
      ST_LOAD: begin
        // A new word may be taken while the previous one shifts its final
        // bit, which keeps chain_e continuous across word boundaries.
        in_ready = (!ser_full || ser_last) && words_left;
        if (ser_last && !words_left) begin
`ifdef CFG_LOADER_CRC_EN
          state_n = ST_CHECK;
`else
          state_n = ST_DONE;
`endif
        end
      end
`ifdef CFG_LOADER_CRC_EN
      ST_CHECK: begin
        in_ready = 1'b1;
        if (stream.in_valid) state_n = ST_DONE;
      end
`endif
      ST_DONE:   state_n = ST_IDLE;
      default:   state_n = ST_IDLE;
    endcase
  end

  // Status outputs are registered from the next state so they line up with
  // the state register and never glitch the asynchronous chain preset.
  always_ff @(posedge clk) begin
    assert (chain_len_ok(CHAIN_LEN, WORD_W) && (PRESET_CYCLES >= 1));
    if (rst) begin
      pre_cnt  <= '0;
      bits_acc <= '0;
      chain_s  <= 1'b1;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      chain_s <= (state_n != ST_PRESET);
      busy    <= (state_n != ST_IDLE);
      done    <= (state_n == ST_DONE);
      if (start_fire)
        pre_cnt <= PW'(PRESET_CYCLES - 1);
      else if ((state == ST_PRESET) && (pre_cnt != '0))
        pre_cnt <= pre_cnt - 1'b1;
      if (start_fire)
        bits_acc <= '0;
      else if (load_fire)
        bits_acc <= bits_acc + TW'(WORD_W);
    end
  end

  cfg_word_serializer #(
    .WORD_W (WORD_W)
  ) u_ser (
    .clk      (clk),
    .rst      (rst),
    .load     (load_fire),
    .word     (stream.in_data),
    .full     (ser_full),
    .last_bit (ser_last),
    .chain_d  (chain_d),
    .chain_e  (chain_e)
  );

`ifdef CFG_LOADER_CRC_EN
  logic [WORD_W-1:0] csum;
  logic              trailer_fire;

  assign trailer_fire = (state == ST_CHECK) && stream.in_valid;

  always_ff @(posedge clk) begin
    if (rst) begin
      csum <= '0;
      err  <= 1'b0;
    end else if (start_fire) begin
      csum <= '0;
      err  <= 1'b0;
    end else begin
      if (load_fire)    csum <= csum ^ stream.in_data;
      if (trailer_fire) err  <= (stream.in_data != csum);
    end
  end
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_cfg_chain_loader.sv
module tb_cfg_chain_loader;

`ifdef CFG_LOADER_CRC_EN
  localparam int CRC_X = 1;
`else
  localparam int CRC_X = 0;
`endif

  // Bits expected on chain_d in shift order: 0xA5 then 0x3C, each LSB first
  // (1,0,1,0,0,1,0,1, 0,0,1,1,1,1,0,0); bit i of this value is shift i.
  localparam logic [15:0] EXP_BITS = 16'h3CA5;

  logic clk = 1'b0;
  logic rst;
  logic start;
  logic chain_d, chain_e, chain_s, busy, done, err;

  cfg_chain_loader_if #(.WORD_W(8)) bus ();

  cfg_chain_loader #(
    .CHAIN_LEN     (16),
    .WORD_W        (8),
    .PRESET_CYCLES (2)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .stream  (bus),
    .chain_d (chain_d),
    .chain_e (chain_e),
    .chain_s (chain_s),
    .busy    (busy),
    .done    (done),
    .err     (err)
  );

  always #5 clk = ~clk;

  int n_total = 0;
  int n_pass  = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  // expected output vector layout: {in_ready, chain_s, chain_e, chain_d, busy, done}
  typedef struct packed {
    logic       start;
    logic       valid;
    logic [7:0] data;
    logic [5:0] exp;
  } vec_t;

  vec_t  vec [23];
  string fld [6] = '{"done", "busy", "chain_d", "chain_e", "chain_s", "in_ready"};

  task automatic chk_outs(input string tag, input logic [5:0] exp);
    logic [5:0] act;
    act = {bus.in_ready, chain_s, chain_e, chain_d, busy, done};
    for (int j = 0; j < 6; j++)
      chk($sformatf("%s %s", tag, fld[j]), int'(act[j]), int'(exp[j]));
    chk($sformatf("%s err", tag), int'(err), 0);
  endtask

  // Results of one load sequence.
  logic [15:0] r_bits;
  int r_nbits, r_gap, r_done_cyc, r_ndone, r_preset, r_first_rdy, r_extra_rdy, r_nacc;
  logic r_err_done, r_err_c1, r_err_end;

  // start at cycle 0; 0xA5 offered from cycle 0, 0x3C from cycle w2_from,
  // then 'trailer' offered continuously (checksum trailer or excess word).
  task automatic run_seq(input int w2_from, input logic [7:0] trailer, input bit pulse_mid);
    int nacc;
    r_bits = '0; r_nbits = 0; r_gap = 0; r_done_cyc = -1; r_ndone = 0;
    r_preset = 0; r_first_rdy = -1; r_extra_rdy = 0;
    r_err_done = 1'b0; r_err_c1 = 1'b0; r_err_end = 1'b0;
    nacc = 0;
    for (int c = 0; c < 60; c++) begin
      @(posedge clk); #1;
      start = (c == 0) || (pulse_mid && c == 8);
      if (nacc == 0) begin
        bus.in_valid = 1'b1; bus.in_data = 8'hA5;
      end else if (nacc == 1) begin
        bus.in_valid = (c >= w2_from); bus.in_data = 8'h3C;
      end else begin
        bus.in_valid = 1'b1; bus.in_data = trailer;
      end
      @(negedge clk);
      if (bus.in_ready && r_first_rdy < 0) r_first_rdy = c;
      if (bus.in_ready && nacc >= 2) r_extra_rdy++;
      if (bus.in_ready && bus.in_valid) nacc++;
      if (chain_e) begin
        if (r_nbits < 16) r_bits[r_nbits] = chain_d;
        r_nbits++;
      end else if (r_nbits > 0 && r_nbits < 16) begin
        r_gap++;
      end
      if (!chain_s) r_preset++;
      if (c == 1) r_err_c1 = err;
      if (done) begin
        r_ndone++; r_done_cyc = c; r_err_done = err;
      end
      r_err_end = err;
      if (r_done_cyc >= 0 && c >= r_done_cyc + 3) break;
    end
    r_nacc = nacc;
    start = 1'b0; bus.in_valid = 1'b0; bus.in_data = 8'h00;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; start = 1'b0; bus.in_valid = 1'b0; bus.in_data = 8'h00;

    // cycle-by-cycle trace of a back-to-back load, start at row 0
    vec[0]  = '{1'b1, 1'b1, 8'hA5, 6'b010000};
    vec[1]  = '{1'b0, 1'b1, 8'hA5, 6'b000010};
    vec[2]  = '{1'b0, 1'b1, 8'hA5, 6'b000010};
    vec[3]  = '{1'b0, 1'b1, 8'hA5, 6'b110010};
    vec[4]  = '{1'b0, 1'b1, 8'h3C, 6'b011110};
    vec[5]  = '{1'b0, 1'b1, 8'h3C, 6'b011010};
    vec[6]  = '{1'b0, 1'b1, 8'h3C, 6'b011110};
    vec[7]  = '{1'b0, 1'b1, 8'h3C, 6'b011010};
    vec[8]  = '{1'b0, 1'b1, 8'h3C, 6'b011010};
    vec[9]  = '{1'b0, 1'b1, 8'h3C, 6'b011110};
    vec[10] = '{1'b0, 1'b1, 8'h3C, 6'b011010};
    vec[11] = '{1'b0, 1'b1, 8'h3C, 6'b111110};
    vec[12] = '{1'b0, 1'b0, 8'h00, 6'b011010};
    vec[13] = '{1'b0, 1'b0, 8'h00, 6'b011010};
    vec[14] = '{1'b0, 1'b0, 8'h00, 6'b011110};
    vec[15] = '{1'b0, 1'b0, 8'h00, 6'b011110};
    vec[16] = '{1'b0, 1'b0, 8'h00, 6'b011110};
    vec[17] = '{1'b0, 1'b0, 8'h00, 6'b011110};
    vec[18] = '{1'b0, 1'b0, 8'h00, 6'b011010};
    vec[19] = '{1'b0, 1'b0, 8'h00, 6'b011010};
`ifdef CFG_LOADER_CRC_EN
    vec[20] = '{1'b0, 1'b1, 8'h99, 6'b110010};
    vec[21] = '{1'b0, 1'b0, 8'h00, 6'b010011};
    vec[22] = '{1'b0, 1'b0, 8'h00, 6'b010000};
`else
    vec[20] = '{1'b0, 1'b0, 8'h00, 6'b010011};
    vec[21] = '{1'b0, 1'b0, 8'h00, 6'b010000};
    vec[22] = '{1'b0, 1'b0, 8'h00, 6'b010000};
`endif

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_outs("reset held", 6'b010000);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk_outs("idle after reset", 6'b010000);

    for (int r = 0; r < 23; r++) begin
      @(posedge clk); #1;
      start        = vec[r].start;
      bus.in_valid = vec[r].valid;
      bus.in_data  = vec[r].data;
      @(negedge clk);
      chk_outs($sformatf("trace cyc%0d", r), vec[r].exp);
    end
    start = 1'b0; bus.in_valid = 1'b0;
    repeat (2) @(posedge clk);

    // three-cycle valid gap between words
    run_seq(14, 8'h99, 1'b0);
    chk("gap bits", int'(r_bits), int'(EXP_BITS));
    chk("gap nbits", r_nbits, 16);
    chk("gap idle cycles", r_gap, 3);
    chk("gap done cycle", r_done_cyc, 23 + CRC_X);
    chk("gap done count", r_ndone, 1);
    chk("gap err", int'(r_err_done), 0);

    // start pulsed mid-load and an excess word offered after the payload
    run_seq(4, 8'h99, 1'b1);
    chk("excess bits", int'(r_bits), int'(EXP_BITS));
    chk("excess done cycle", r_done_cyc, 20 + CRC_X);
    chk("excess done count", r_ndone, 1);
    chk("excess ready after payload", r_extra_rdy, CRC_X);
    chk("excess words accepted", r_nacc, 2 + CRC_X);

    // reset in the middle of a load
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      start        = (c == 0);
      bus.in_valid = (c < 9);
      bus.in_data  = (c <= 3) ? 8'hA5 : 8'h3C;
      rst          = (c == 8);
      if (c == 9) begin
        @(negedge clk);
        chk_outs("after mid-load reset", 6'b010000);
      end
    end
    start = 1'b0; bus.in_valid = 1'b0;
    @(posedge clk); #1;
    run_seq(4, 8'h99, 1'b0);
    chk("reload preset cycles", r_preset, 2);
    chk("reload first ready", r_first_rdy, 3);
    chk("reload bits", int'(r_bits), int'(EXP_BITS));
    chk("reload gap", r_gap, 0);
    chk("reload done cycle", r_done_cyc, 20 + CRC_X);

`ifdef CFG_LOADER_CRC_EN
    run_seq(4, 8'h00, 1'b0);
    chk("crc bad err at done", int'(r_err_done), 1);
    chk("crc bad err held", int'(r_err_end), 1);
    chk("crc bad done count", r_ndone, 1);
    run_seq(4, 8'h99, 1'b0);
    chk("crc err cleared by start", int'(r_err_c1), 0);
    chk("crc good err at done", int'(r_err_done), 0);
    chk("crc good done cycle", r_done_cyc, 21);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
